// File: rtl/resp_capture_misr.sv
// resp_capture_misr: captures the response beats of a test run into a 16-bit
// multiple-input signature register (MISR).
// Each run is started by a one-cycle start pulse and runs for num_vec beats.
// Optional feature: define RESP_PARITY_CHK_EN to add the resp_par input and
// the sticky par_err output, which flags even-parity errors on accepted beats.
module resp_capture_misr #(
  parameter logic [15:0] SEED = 16'hFFFF,
  parameter logic [15:0] POLY = 16'h1021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_vec,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  resp,
  output logic [15:0] sig,
  output logic        sig_valid,
  output logic        busy,
`ifdef RESP_PARITY_CHK_EN
  output logic [15:0] vec_count,
  input  logic        resp_par,
  output logic        par_err
`else
  output logic [15:0] vec_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] num_lat;
  logic [15:0] misr_next;
  logic        xfer;
  logic        start_acc;
  logic        last_beat;

  // A start is honoured only from IDLE or DONE; a beat moves only in RUN.
  assign start_acc = start && ((state == IDLE) || (state == DONE));
  assign in_ready  = (state == RUN);
  assign xfer      = in_valid && in_ready;
  assign last_beat = (vec_count == (num_lat - 16'd1));
  assign busy      = (state == RUN);
  assign sig_valid = (state == DONE);

  // Next signature: shift left, fold back the taps when the MSB falls out,
  // then mix in the response byte at the bottom.
  assign misr_next = {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0000) ^ {8'h00, resp};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (num_vec != 16'd0) ? RUN : DONE;
      end
      RUN: begin
        if (xfer && last_beat) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Signature, beat counter and run length: reset/start initialise, each
  // accepted beat advances; everything holds otherwise (bubbles, DONE).
  always_ff @(posedge clk) begin
    if (rst) begin
      sig       <= SEED;
      vec_count <= 16'd0;
      num_lat   <= 16'd0;
    end else if (start_acc) begin
      sig       <= SEED;
      vec_count <= 16'd0;
      num_lat   <= num_vec;
    end else if (xfer) begin
      sig       <= misr_next;
      vec_count <= vec_count + 16'd1;
    end
  end

`ifdef RESP_PARITY_CHK_EN
  // Sticky parity error: set on any accepted beat with bad even parity,
  // cleared by reset or by the start of a new run.
  always_ff @(posedge clk) begin
    if (rst)                            par_err <= 1'b0;
    else if (start_acc)                 par_err <= 1'b0;
    else if (xfer && ((^resp) != resp_par)) par_err <= 1'b1;
  end
`endif

endmodule

// File: doc/resp_capture_misr.md
RESP_CAPTURE_MISR -- requirements
Module: resp_capture_misr

Interface
REQ-001 The block SHALL have parameter SEED, default 16'hFFFF, the MISR value loaded at run start.
REQ-002 The block SHALL have parameter POLY, default 16'h1021, the MISR feedback taps for x^16+x^12+x^5+1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a capture run.
REQ-006 The block SHALL have port num_vec, input, 16 bits: vectors per run, sampled on the accepted start.
REQ-007 The block SHALL have port in_valid, input, 1 bit: resp holds a valid response beat.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 The block SHALL have port resp, input, 8 bits: upstream combinational cone outputs packed {n77,n68,n65,n56,n48,n42,n9,n6}, with n6 at bit 0.
REQ-010 The block SHALL have port sig, output, 16 bits: the current MISR signature.
REQ-011 The block SHALL have port sig_valid, output, 1 bit: sig is final for the completed run.
REQ-012 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-013 The block SHALL have port vec_count, output, 16 bits: beats accepted in the current or last run.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, encoded in 2 bits; the unused encoding SHALL return to IDLE on the next cycle.
REQ-015 From IDLE or DONE, start=1 SHALL load sig=SEED, clear vec_count to 0, latch num_vec and clear sig_valid, all in the same edge.
- Next state is RUN if the latched num_vec != 0, else DONE.
REQ-016 In RUN, start SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in RUN, driven combinationally from the state register; a beat transfers when in_valid && in_ready.
REQ-018 On each transfer, sig SHALL update at the next edge to ({sig[14:0],1'b0} ^ (sig[15] ? POLY : 0) ^ {8'h00,resp}).
- Latency from transfer to updated sig: 1 cycle.
REQ-019 On each transfer, vec_count SHALL increment by 1, modulo 2^16.
REQ-020 A transfer with vec_count == latched num_vec-1 SHALL move the FSM to DONE on the same edge.
REQ-021 In DONE, sig_valid SHALL be 1, and sig and vec_count SHALL hold until the next start or rst.
REQ-022 busy SHALL equal (state == RUN).
REQ-023 in_valid with in_ready=0 SHALL leave sig and vec_count unchanged; resp is don't-care when in_valid=0.
REQ-024 In RUN, cycles with in_valid=0 SHALL not advance state, sig or vec_count (bubbles are allowed).

Reset
REQ-025 rst=1 SHALL override all other inputs, including start and transfers in the same cycle.
- state=IDLE, sig=SEED, vec_count=0, sig_valid=0, busy=0, in_ready=0 at the next edge.
REQ-026 rst asserted mid-RUN SHALL abandon the run; no partial signature is flagged valid.

Configuration
REQ-027 With macro RESP_PARITY_CHK_EN defined, the block SHALL add input resp_par (1 bit, even parity of resp) and output par_err (1 bit, sticky).
- par_err sets on any transfer where ^resp != resp_par.
- par_err clears on rst or an accepted start.
- par_err resets to 0.
REQ-028 Without RESP_PARITY_CHK_EN, the block SHALL omit resp_par and par_err, and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover a single vector: start with num_vec=1, then one beat resp=8'h00 -> sig=16'hEFDF, sig_valid=1, vec_count=1, busy=0.
REQ-030 The bench SHALL cover two vectors: num_vec=2, beats 8'h01 then 8'h00.
- After beat 1: sig=16'hEFDE.
- After beat 2: sig=16'hCF9D; sig_valid rises the cycle after the second transfer.
REQ-031 The bench SHALL cover an empty run: start with num_vec=0 -> DONE next cycle, sig=16'hFFFF, sig_valid=1, no beat accepted.
REQ-032 The bench SHALL cover bubbles and backpressure.
- num_vec=3 with in_valid gaps between beats -> result identical to the gap-free run.
- in_valid held in IDLE -> no transfer, in_ready=0.
REQ-033 The bench SHALL cover reset mid-run and a start during RUN.
- rst asserted after 2 of 4 beats -> IDLE, sig=16'hFFFF, vec_count=0, sig_valid=0.
- start pulsed in RUN -> ignored, vec_count continues.
REQ-034 The bench SHALL cover parity, with RESP_PARITY_CHK_EN defined: beat resp=8'h03 with resp_par=1 -> par_err=1, held through DONE, cleared by the next start.
